serial_frame_deserializer: RTL and testbench

//  Receive side of the serial link: recovers framed {k,8-bit} symbols from one bit-serial line.
//  - Runs on the link bit clock, one bit per clock; no oversampling.
//  - Feeds its symbol strobe and data to the Wishbone read path.
//  - Packs three consecutive symbols into one 27-bit packet word, matching the TX packet layout.

---
 rtl/serial_frame_deserializer.sv | 163 ++++++++++++++++
 tb/tb_serial_frame_deserializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// Bit-serial receiver: recovers framed {k, data[7:0]} symbols and packs NSYM of them into a packet word.
// Optional even-parity bit per frame is built when DESER_PARITY_EN is defined.
module serial_frame_deserializer #(
  parameter int WIDTH = 10,
  parameter int NSYM  = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          serial_i,
  output logic [WIDTH-2:0]              data_o,
  output logic                          eob_o,
  output logic                          err_o,
  output logic [NSYM*(WIDTH-1)-1:0]     word_o,
  output logic                          pkt_o
);

  localparam int PW = WIDTH - 1;
  localparam int WW = NSYM * PW;
  localparam int CW = $clog2(WIDTH);
  localparam int SW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 2);
  localparam logic [SW-1:0] LAST_SYM = SW'(NSYM - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
`ifdef DESER_PARITY_EN
  localparam logic [1:0] ST_PAR  = 2'd2;
`endif
  localparam logic [1:0] ST_STOP = 2'd3;

  // Handshake: eob_o/err_o/pkt_o are single-cycle strobes with no back-pressure;
  // data_o and word_o are valid in the strobe cycle and held until the next good update.

  logic [1:0]    sync_q;
  logic          s;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] shift_q, shift_d;
  logic [SW-1:0] sym_q, sym_d;
  logic [WW-1:0] buf_q, buf_d;
  logic [PW-1:0] data_q, data_d;
  logic [WW-1:0] word_q, word_d;
  logic          eob_q, eob_d;
  logic          err_q, err_d;
  logic          pkt_q, pkt_d;
  logic          good;

  assign s = sync_q[1];

`ifdef DESER_PARITY_EN
  logic par_err_q, par_err_d;
  assign good = s & ~par_err_q;
`else
  assign good = s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    sym_d   = sym_q;
    buf_d   = buf_q;
    data_d  = data_q;
    word_d  = word_q;
    eob_d   = 1'b0;
    err_d   = 1'b0;
    pkt_d   = 1'b0;
`ifdef DESER_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!s) begin
          state_d = ST_DATA;
          cnt_d   = '0;
`ifdef DESER_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        shift_d = {s, shift_q[PW-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
`ifdef DESER_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef DESER_PARITY_EN
      ST_PAR: begin
        par_err_d = s ^ (^shift_q);
        state_d   = ST_STOP;
      end
`endif
      ST_STOP: begin
        state_d = ST_IDLE;
        if (good) begin
          data_d = shift_q;
          eob_d  = 1'b1;
          // Slot 0 lands in the MSBs so the word reads [s0][s1]...[sN-1].
          for (int i = 0; i < NSYM; i++) begin
            if (sym_q == SW'(i)) buf_d[(NSYM-1-i)*PW +: PW] = shift_q;
          end
          if (sym_q == LAST_SYM) begin
            word_d = buf_d;
            pkt_d  = 1'b1;
            sym_d  = '0;
          end else begin
            sym_d = sym_q + 1'b1;
          end
        end else begin
          err_d = 1'b1;
          sym_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      sym_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      word_q  <= '0;
      eob_q   <= 1'b0;
      err_q   <= 1'b0;
      pkt_q   <= 1'b0;
`ifdef DESER_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], serial_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sym_q   <= sym_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      word_q  <= word_d;
      eob_q   <= eob_d;
      err_q   <= err_d;
      pkt_q   <= pkt_d;
`ifdef DESER_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign data_o = data_q;
  assign word_o = word_q;
  assign eob_o  = eob_q;
  assign err_o  = err_q;
  assign pkt_o  = pkt_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer: vector table, directed sequences and random frames
// compared cycle by cycle against a frame-level reference model.
module tb_serial_frame_deserializer;
  localparam int WIDTH = 10;
  localparam int NSYM  = 3;
  localparam int PW    = WIDTH - 1;
  localparam int WW    = NSYM * PW;
`ifdef DESER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          serial = 1'b1;
  logic [PW-1:0] data;
  logic          eob, err, pkt;
  logic [WW-1:0] word;

  serial_frame_deserializer #(.WIDTH(WIDTH), .NSYM(NSYM)) dut (
    .clk_i(clk), .rst_i(rst), .serial_i(serial),
    .data_o(data), .eob_o(eob), .err_o(err), .word_o(word), .pkt_o(pkt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int            cyc;
    logic          good;
    logic [PW-1:0] payload;
  } ev_t;

  typedef struct {
    logic [PW-1:0] payload;
    logic          stop;
    logic          par_flip;
    logic          exp_eob;
    logic          exp_err;
    logic          exp_pkt;
    logic [PW-1:0] exp_data;
  } vec_t;

  // reference model state and stimulus stream
  logic [PW-1:0] m_data;
  logic [WW-1:0] m_word;
  logic [PW-1:0] m_pend[$];
  logic          stream_q[$];
  ev_t           ev_q[$];

  int            obs_eob, obs_err, obs_pkt;
  logic [WW-1:0] obs_word;
  logic [PW-1:0] obs_err_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // driver: one frame onto the stream
  task automatic push_frame(input logic [PW-1:0] p, input logic stop, input logic par_flip);
    stream_q.push_back(1'b0);
    for (int b = 0; b < PW; b++) stream_q.push_back(p[b]);
`ifdef DESER_PARITY_EN
    stream_q.push_back((^p) ^ par_flip);
`else
    if (par_flip) stream_q.push_back(1'b1);
`endif
    stream_q.push_back(stop);
  endtask

  // frame-level parse of the bit stream; result appears 3 cycles after the stop bit
  function automatic void parse_stream();
    int i;
    int len;
    i = 0;
    len = stream_q.size();
    ev_q.delete();
    while (i < len) begin
      if (stream_q[i] == 1'b0) begin
        ev_t           e;
        logic [PW-1:0] p;
        int            stop_i;
        logic          ok;
        stop_i = i + PW + 1 + PAR_BITS;
        if (stop_i >= len) break;
        for (int b = 0; b < PW; b++) p[b] = stream_q[i + 1 + b];
        ok = stream_q[stop_i];
`ifdef DESER_PARITY_EN
        if (stream_q[i + 1 + PW] != ^p) ok = 1'b0;
`endif
        e.cyc = stop_i + 3;
        e.good = ok;
        e.payload = p;
        ev_q.push_back(e);
        i = stop_i + 1;
      end else begin
        i++;
      end
    end
  endfunction

  // scoreboard: drive the stream, compare every cycle against the model
  task automatic run_stream(input int tail);
    int   len;
    ev_t  e;
    logic x_eob, x_err, x_pkt;
    len = stream_q.size();
    parse_stream();
    obs_eob = 0; obs_err = 0; obs_pkt = 0;
    for (int c = 0; c < len + tail; c++) begin
      @(posedge clk);
      #1 serial = (c < len) ? stream_q[c] : 1'b1;
      @(negedge clk);
      x_eob = 1'b0; x_err = 1'b0; x_pkt = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].cyc == c) begin
        e = ev_q.pop_front();
        if (e.good) begin
          x_eob = 1'b1;
          m_data = e.payload;
          m_pend.push_back(e.payload);
          if (m_pend.size() == NSYM) begin
            x_pkt = 1'b1;
            m_word = '0;
            foreach (m_pend[j]) m_word = {m_word[WW-PW-1:0], m_pend[j]};
            m_pend.delete();
          end
        end else begin
          x_err = 1'b1;
          m_pend.delete();
        end
      end
      check($sformatf("pulses cyc %0d", c), {61'd0, eob, err, pkt}, {61'd0, x_eob, x_err, x_pkt});
      check($sformatf("data_o cyc %0d", c), 64'(data), 64'(m_data));
      check($sformatf("word_o cyc %0d", c), 64'(word), 64'(m_word));
      if (eob) obs_eob++;
      if (err) begin obs_err++; obs_err_data = data; end
      if (pkt) begin obs_pkt++; obs_word = word; end
    end
    stream_q.delete();
  endtask

  task automatic do_reset();
    serial = 1'b1;
    rst = 1'b1;
    m_data = '0; m_word = '0; m_pend.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 64'({eob, err, pkt, data, word}), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    vec_t tbl[$];

    // vector table: expected values follow from the frame rules alone
    tbl.push_back('{9'h1BC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h1BC});
    tbl.push_back('{9'h055, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h1BC});
    tbl.push_back('{9'h0AA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0AA});
    tbl.push_back('{9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h000});
    tbl.push_back('{9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'h1FF});
    tbl.push_back('{9'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h1FF});
`ifdef DESER_PARITY_EN
    tbl.push_back('{9'h0FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0FF});
    tbl.push_back('{9'h0FF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0FF});
`endif

    // reset and idle line
    do_reset();
    run_stream(50);
    check("idle eob count", 64'(obs_eob), 64'd0);
    check("idle err count", 64'(obs_err), 64'd0);

    // table-driven single frames
    do_reset();
    foreach (tbl[v]) begin
      push_frame(tbl[v].payload, tbl[v].stop, tbl[v].par_flip);
      run_stream(4);
      check($sformatf("tbl %0d eob", v), 64'(obs_eob != 0), 64'(tbl[v].exp_eob));
      check($sformatf("tbl %0d err", v), 64'(obs_err != 0), 64'(tbl[v].exp_err));
      check($sformatf("tbl %0d pkt", v), 64'(obs_pkt != 0), 64'(tbl[v].exp_pkt));
      check($sformatf("tbl %0d data", v), 64'(data), 64'(tbl[v].exp_data));
    end

    // three symbols back to back form one packet
    do_reset();
    push_frame(9'h1BC, 1'b1, 1'b0);
    push_frame(9'h055, 1'b1, 1'b0);
    push_frame(9'h0AA, 1'b1, 1'b0);
    run_stream(4);
    check("b2b eob count", 64'(obs_eob), 64'd3);
    check("b2b pkt count", 64'(obs_pkt), 64'd1);
    check("b2b word", 64'(obs_word), 64'(27'h6F0_AAAA));

    // bad stop bit discards the partial packet
    do_reset();
    push_frame(9'h012, 1'b1, 1'b0);
    push_frame(9'h0AB, 1'b0, 1'b0);
    push_frame(9'h034, 1'b1, 1'b0);
    push_frame(9'h056, 1'b1, 1'b0);
    push_frame(9'h078, 1'b1, 1'b0);
    run_stream(4);
    check("err count", 64'(obs_err), 64'd1);
    check("data during err", 64'(obs_err_data), 64'(9'h012));
    check("err pkt count", 64'(obs_pkt), 64'd1);
    check("err word", 64'(obs_word), 64'({9'h034, 9'h056, 9'h078}));

    // reset in the middle of payload bit 4
    do_reset();
    push_frame(9'h1BC, 1'b1, 1'b0);
    stream_q.push_back(1'b0);
    for (int b = 0; b < 5; b++) stream_q.push_back(1'b1);
    run_stream(0);
    rst = 1'b1;
    #1;
    check("mid-frame reset outputs", 64'({eob, err, pkt, data, word}), 64'd0);
    serial = 1'b1;
    m_data = '0; m_word = '0; m_pend.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    push_frame(9'h0FF, 1'b1, 1'b0);
    run_stream(4);
    check("post-reset eob count", 64'(obs_eob), 64'd1);
    check("post-reset data", 64'(data), 64'(9'h0FF));

    // random frames, gaps and errors against the model
    do_reset();
    for (int f = 0; f < 60; f++) begin
      push_frame(9'($urandom_range(0, 511)), ($urandom_range(0, 7) != 0),
                 (PAR_BITS == 1) && ($urandom_range(0, 7) == 0));
      for (int g = $urandom_range(0, 3); g > 0; g--) stream_q.push_back(1'b1);
    end
    run_stream(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
